// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive front end.
// The UART_RX_SYNC_EN build option is handled inside uart_rx_data_sampler.
package uart_rx_pkg;

   localparam int PRESCALE_W_DEF = 6;
   localparam int BIT_CNT_W_DEF  = 4;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (b & c) | (a & c);
   endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and frame bit counter.
// The oversampling ratio is latched on each rising edge of sample_enable_i.
module uart_rx_edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF,
   parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
   input  logic                  clk_based_on_prescale,
   input  logic                  asy_reset,
   input  logic                  sample_enable_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic [PRESCALE_W-1:0] edge_cnt_o,
   output logic [BIT_CNT_W-1:0]  bit_cnt_o,
   output logic [PRESCALE_W-1:0] half_o
);

   localparam logic [PRESCALE_W-1:0] P8    = PRESCALE_W'(PRESCALE_8);
   localparam logic [PRESCALE_W-1:0] P16   = PRESCALE_W'(PRESCALE_16);
   localparam logic [PRESCALE_W-1:0] P32   = PRESCALE_W'(PRESCALE_32);
   localparam logic [PRESCALE_W-1:0] E_ONE = PRESCALE_W'(1);
   localparam logic [BIT_CNT_W-1:0]  B_ONE = BIT_CNT_W'(1);

   logic                  en_prev_q;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] prescale_legal, prescale_eff;
   logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

   // The enabling cycle already runs on the freshly latched ratio.
   always_comb begin
      prescale_legal = (prescale_i == P16 || prescale_i == P32) ? prescale_i : P8;
      prescale_eff   = (sample_enable_i && !en_prev_q) ? prescale_legal : prescale_q;
      prescale_d     = sample_enable_i ? prescale_eff : prescale_q;
      edge_cnt_d     = '0;
      bit_cnt_d      = '0;
      if (sample_enable_i) begin
         if (edge_cnt_q == prescale_eff - E_ONE) begin
            edge_cnt_d = '0;
            bit_cnt_d  = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + B_ONE;
         end else begin
            edge_cnt_d = edge_cnt_q + E_ONE;
            bit_cnt_d  = bit_cnt_q;
         end
      end
   end

   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset) begin
         en_prev_q  <= 1'b0;
         prescale_q <= '0;
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         en_prev_q  <= sample_enable_i;
         prescale_q <= prescale_d;
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign edge_cnt_o = edge_cnt_q;
   assign bit_cnt_o  = bit_cnt_q;
   assign half_o     = prescale_eff >> 1;

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampler: three samples around each bit centre, majority vote, one strobe per bit.
// Define UART_RX_SYNC_EN to add a 2-flop input synchronizer and the rx_sync output.
module uart_rx_data_sampler
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF,
   parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
   input  logic                  clk_based_on_prescale,
   input  logic                  asy_reset,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  sample_enable,
   output logic                  sampled_data,
   output logic                  sampled_data_valid,
`ifdef UART_RX_SYNC_EN
   output logic                  rx_sync,
`endif
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt
);

   localparam logic [PRESCALE_W-1:0] E_ONE = PRESCALE_W'(1);

   logic                  rx_samp;
   logic [PRESCALE_W-1:0] half;
   logic [PRESCALE_W-1:0] win_start;
   logic [2:0]            tap_hit;
   logic [2:0]            s_q, s_d;
   logic                  vote_now;
   logic                  data_q, data_d;
   logic                  valid_q, valid_d;

`ifdef UART_RX_SYNC_EN
   logic rx_meta_q, rx_sync_q;

   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_in;
         rx_sync_q <= rx_meta_q;
      end
   end

   assign rx_samp = rx_sync_q;
   assign rx_sync = rx_sync_q;
`else
   assign rx_samp = rx_in;
`endif

   uart_rx_edge_bit_counter #(
      .PRESCALE_W (PRESCALE_W),
      .BIT_CNT_W  (BIT_CNT_W)
   ) u_counter (
      .clk_based_on_prescale (clk_based_on_prescale),
      .asy_reset             (asy_reset),
      .sample_enable_i       (sample_enable),
      .prescale_i            (prescale),
      .edge_cnt_o            (edge_cnt),
      .bit_cnt_o             (bit_cnt),
      .half_o                (half)
   );

   assign win_start = half - E_ONE;

   // Taps at half-1, half, half+1; each bit period overwrites all three.
   for (genvar gi = 0; gi < 3; gi++) begin : g_tap
      localparam logic [PRESCALE_W-1:0] TAP_OFS = PRESCALE_W'(gi);
      assign tap_hit[gi] = (edge_cnt == win_start + TAP_OFS);
      assign s_d[gi]     = (sample_enable && tap_hit[gi]) ? rx_samp : s_q[gi];
   end

   // Last sample goes straight into the vote so the strobe lands at half+2.
   always_comb begin
      vote_now = sample_enable && tap_hit[2];
      valid_d  = vote_now;
      data_d   = vote_now ? majority3(s_q[0], s_q[1], rx_samp) : data_q;
   end

   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset) begin
         s_q     <= '0;
         data_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         s_q     <= s_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign sampled_data       = data_q;
   assign sampled_data_valid = valid_q;

endmodule
